// File: rtl/if_prefetch_pkg.sv
// Shared CPU defines used by the instruction-fetch front end: bus widths,
// reset vector, default queue geometry and the fetch-engine state type.
package if_prefetch_pkg;

    // Instruction-side bus widths and the reset vector of the core
    localparam int unsigned CPU_IADDR_W   = 32;
    localparam int unsigned CPU_IDATA_W   = 32;
    localparam int unsigned CPU_RESET_VEC = 32'h0000_0000;

    // Default prefetch queue geometry
    localparam int unsigned IFQ_DEPTH     = 4;
    localparam int unsigned IFQ_PC_STEP   = 4;

    // Fetch engine: idle right after reset, running from the next edge on
    typedef enum logic {
        StIdle,
        StRun
    } pf_state_e;

    // Pointer width for a queue of the given depth (at least one bit)
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// ifq_fifo: prefetch queue storage holding {pc, instruction} pairs.
// Pointers wrap naturally (DEPTH is a power of two); count spans 0..DEPTH.
// flush_i empties the queue and returns both pointers to zero.
module ifq_fifo
    import if_prefetch_pkg::*;
#(
    parameter int unsigned ADDR_W = CPU_IADDR_W,
    parameter int unsigned DATA_W = CPU_IDATA_W,
    parameter int unsigned DEPTH  = IFQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [DATA_W-1:0] push_inst_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_inst_o
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
    logic [DATA_W-1:0] inst_mem_q [DEPTH];
    logic [DATA_W-1:0] inst_mem_d [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Never overrun or underrun, even if the caller misbehaves
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Head entry, forced to zero while the queue is empty
    always_comb begin
        head_pc_o   = '0;
        head_inst_o = '0;
        if (!empty_o) begin
            head_pc_o   = pc_mem_q[rd_ptr_q];
            head_inst_o = inst_mem_q[rd_ptr_q];
        end
    end

    // Next-state for storage, pointers and occupancy
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                pc_mem_d[wr_ptr_q]   = push_pc_i;
                inst_mem_d[wr_ptr_q] = push_inst_i;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Queue state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetch front end. Fetches sequentially from a
// combinational ROM into a small queue and presents the head to decode.
// A branch request flushes the queue and redirects fetch the next cycle.
// Optional performance counters are enabled by defining IF_PREFETCH_PERF_EN.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = CPU_IADDR_W,
    parameter int unsigned DATA_W   = CPU_IDATA_W,
    parameter int unsigned DEPTH    = IFQ_DEPTH,
    parameter int unsigned RESET_PC = CPU_RESET_VEC,
    parameter int unsigned PC_STEP  = IFQ_PC_STEP
) (
    input  logic              clk,
    input  logic              rst,
`ifdef IF_PREFETCH_PERF_EN
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o,
`endif
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_ce_o,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    input  logic              id_ready_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i
);

    pf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

    logic q_full;
    logic q_empty;
    logic push;
    logic pop;

    // A branch takes priority: no push, no pop, queue flushed
    assign push = (state_q == StRun) && !q_full && !branch_i;
    assign pop  = !q_empty && id_ready_i && !branch_i;

    assign rom_ce_o   = push;
    assign rom_addr_o = fetch_pc_q;
    assign id_valid_o = !q_empty;

    // Fetch engine: start running on the first edge after reset release
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // Next fetch address: redirect, sequential advance, or hold
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (branch_i) begin
            fetch_pc_d = branch_target_i;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        end
    end

    // Fetch engine and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= ADDR_W'(RESET_PC);
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    ifq_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ifq_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_pc_i   (fetch_pc_q),
        .push_inst_i (rom_data_i),
        .pop_i       (pop),
        .flush_i     (branch_i),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .head_pc_o   (id_pc_o),
        .head_inst_o (id_inst_o)
    );

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

    // Count pushes and cycles where decode holds a valid head
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (push) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (id_valid_o && !id_ready_i && !branch_i) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Performance counter registers, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    // Performance counters not built in this configuration
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch (default parameters, DEPTH=4, PC_STEP=4).
// The ROM model returns addr + 0x1000_0000 so pc/instruction mix-ups show up.
module tb_if_prefetch;

    localparam logic [31:0] ROM_OFS = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_data_i;
    logic [31:0] rom_addr_o;
    logic        rom_ce_o;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_ready_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rom_data_i = rom_addr_o + ROM_OFS;

    if_prefetch dut (
        .clk             (clk),
        .rst             (rst),
`ifdef IF_PREFETCH_PERF_EN
        .fetch_cnt_o     (fetch_cnt_o),
        .stall_cnt_o     (stall_cnt_o),
`endif
        .rom_data_i      (rom_data_i),
        .rom_addr_o      (rom_addr_o),
        .rom_ce_o        (rom_ce_o),
        .id_valid_o      (id_valid_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_ready_i      (id_ready_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i)
    );

    typedef struct {
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        ce;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t row(input logic rdy, input logic br, input logic [31:0] tgt,
                                 input logic ce, input logic [31:0] addr, input logic vld,
                                 input logic [31:0] pc);
        vec_t v;
        v.rdy = rdy; v.br = br; v.tgt = tgt;
        v.ce = ce; v.addr = addr; v.vld = vld; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Compare all decode/ROM-side outputs; inst follows from pc via the ROM model
    task automatic check_out(input string tag, input logic ce, input logic [31:0] addr,
                             input logic vld, input logic [31:0] pc);
        chk({tag, " rom_ce"}, {31'b0, rom_ce_o}, {31'b0, ce});
        chk({tag, " rom_addr"}, rom_addr_o, addr);
        chk({tag, " id_valid"}, {31'b0, id_valid_o}, {31'b0, vld});
        chk({tag, " id_pc"}, id_pc_o, vld ? pc : 32'h0);
        chk({tag, " id_inst"}, id_inst_o, vld ? pc + ROM_OFS : 32'h0);
    endtask

    // Optionally wait for the next edge, then drive inputs and let them settle
    task automatic apply(input bit adv, input logic rdy, input logic br, input logic [31:0] tgt);
        if (adv) begin
            @(posedge clk);
            #1;
        end
        id_ready_i      = rdy;
        branch_i        = br;
        branch_target_i = tgt;
        #1;
    endtask

    // Hold reset for two edges; release just after an edge (that cycle is cycle 0)
    task automatic do_reset();
        rst             = 1'b1;
        id_ready_i      = 1'b0;
        branch_i        = 1'b0;
        branch_target_i = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        check_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;

        // Stall from reset until full, drain, then branch to 0x100
        tbl[0]  = row(1'b0, 1'b0, 32'h0,   1'b0, 32'h00,  1'b0, 32'h0);
        tbl[1]  = row(1'b0, 1'b0, 32'h0,   1'b1, 32'h00,  1'b0, 32'h0);
        tbl[2]  = row(1'b0, 1'b0, 32'h0,   1'b1, 32'h04,  1'b1, 32'h0);
        tbl[3]  = row(1'b0, 1'b0, 32'h0,   1'b1, 32'h08,  1'b1, 32'h0);
        tbl[4]  = row(1'b0, 1'b0, 32'h0,   1'b1, 32'h0C,  1'b1, 32'h0);
        tbl[5]  = row(1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0);
        tbl[6]  = row(1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0);
        tbl[7]  = row(1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h4);
        tbl[8]  = row(1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h8);
        tbl[9]  = row(1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'hC);
        tbl[10] = row(1'b1, 1'b1, 32'h100, 1'b0, 32'h1C,  1'b1, 32'h10);
        tbl[11] = row(1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0);
        tbl[12] = row(1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100);
        tbl[13] = row(1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104);
        tbl[14] = row(1'b1, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104);
        tbl[15] = row(1'b1, 1'b0, 32'h0,   1'b1, 32'h110, 1'b1, 32'h108);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(i != 0, tbl[i].rdy, tbl[i].br, tbl[i].tgt);
            check_out($sformatf("row%0d", i), tbl[i].ce, tbl[i].addr, tbl[i].vld, tbl[i].pc);
        end

        // Branch with the queue full
        do_reset();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i < 5; i++) apply(1'b1, 1'b0, 1'b0, 32'h0);
        apply(1'b1, 1'b1, 1'b1, 32'h100);
        check_out("brfull t", 1'b0, 32'h10, 1'b1, 32'h0);
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        check_out("brfull t+1", 1'b1, 32'h100, 1'b0, 32'h0);
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        check_out("brfull t+2", 1'b1, 32'h104, 1'b1, 32'h100);

        // Full queue drained one per cycle; order kept across several wraps
        do_reset();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i < 6; i++) apply(1'b1, 1'b0, 1'b0, 32'h0);
        check_out("wrap full", 1'b0, 32'h10, 1'b1, 32'h0);
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        check_out("wrap first pop", 1'b0, 32'h10, 1'b1, 32'h0);
        exp_pc   = 32'h4;
        exp_addr = 32'h10;
        for (int k = 0; k < 20; k++) begin
            apply(1'b1, 1'b1, 1'b0, 32'h0);
            check_out($sformatf("wrap%0d", k), 1'b1, exp_addr, 1'b1, exp_pc);
            exp_pc   = exp_pc + 32'h4;
            exp_addr = exp_addr + 32'h4;
        end

        // Asynchronous reset mid-stream, away from any clock edge
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_out("async rst", 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(1'b0, 1'b1, 1'b0, 32'h0);
        check_out("rerun c0", 1'b0, 32'h0, 1'b0, 32'h0);
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        check_out("rerun c1", 1'b1, 32'h0, 1'b0, 32'h0);
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        check_out("rerun c2", 1'b1, 32'h4, 1'b1, 32'h0);
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        check_out("rerun c3", 1'b1, 32'h8, 1'b1, 32'h4);

`ifdef IF_PREFETCH_PERF_EN
        // 10 stalled valid cycles (c2..c11), 4 + 16 fetches
        do_reset();
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i < 12; i++) apply(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 12; i < 30; i++) apply(1'b1, 1'b1, 1'b0, 32'h0);
        chk("perf fetch_cnt", fetch_cnt_o, 32'd20);
        chk("perf stall_cnt", stall_cnt_o, 32'd10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC/ROM address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries (power of 2, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-005 SHALL have parameter PC_STEP, default 4, meaning sequential address increment.
REQ-006 SHALL have port clk  input  1  the only clock; all state changes on the rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port rom_data_i  input  DATA_W  ROM word for rom_addr_o, valid in the same cycle (combinational ROM).
REQ-009 SHALL have port rom_addr_o  output  ADDR_W  fetch address.
REQ-010 SHALL have port rom_ce_o  output  1  ROM enable; a fetch occurs in every cycle it is high.
REQ-011 SHALL have port id_valid_o  output  1  queue head valid.
REQ-012 SHALL have port id_pc_o  output  ADDR_W  head PC.
REQ-013 SHALL have port id_inst_o  output  DATA_W  head instruction.
REQ-014 SHALL have port id_ready_i  input  1  decode accepts head (low = stall).
REQ-015 SHALL have port branch_i  input  1  redirect request from decode.
REQ-016 SHALL have port branch_target_i  input  ADDR_W  redirect address.

Function
REQ-017 SHALL hold internal run flag, fetch_pc, count (0..DEPTH), wr/rd pointers of log2(DEPTH) bits wrapping naturally.
REQ-018 SHALL drive rom_ce_o = run && (count < DEPTH) && !branch_i; rom_addr_o = fetch_pc at all times.
REQ-019 SHALL, on rom_ce_o, push {fetch_pc, rom_data_i} at wr pointer and advance fetch_pc by PC_STEP modulo 2^ADDR_W.
REQ-020 SHALL drive id_valid_o = (count != 0); id_pc_o/id_inst_o from rd-pointer entry, zero when count==0.
REQ-021 SHALL pop when id_valid_o && id_ready_i && !branch_i.
REQ-022 SHALL keep count unchanged on simultaneous push and pop; push blocked only by count==DEPTH (pop same cycle does not enable push).
REQ-023 SHALL, on branch_i, discard all entries (count=0, rd=wr=0), ignore id_ready_i, not push, load fetch_pc = branch_target_i.
REQ-024 SHALL set run 1 on the first edge after reset deassertion: first fetch cycle 1, first id_valid_o cycle 2, PC = RESET_PC.
REQ-025 SHALL give branch latency: branch_i in cycle t -> rom_addr_o = target with rom_ce_o=1 in t+1 -> id_valid_o with id_pc_o = target in t+2.
REQ-026 SHALL keep stored entries stable while id_ready_i low; no entry lost or duplicated.

Reset
REQ-027 SHALL, while rst high, force run=0, fetch_pc=RESET_PC, count=0, pointers=0; rom_ce_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0.
REQ-028 SHALL abandon any in-flight state on rst assertion mid-operation; restart exactly as REQ-024.

Configuration
REQ-029 SHALL, with IF_PREFETCH_PERF_EN defined, add outputs fetch_cnt_o (32) counting pushes and stall_cnt_o (32) counting cycles with id_valid_o && !id_ready_i && !branch_i; both wrap at 2^32, cleared by reset.
REQ-030 SHALL, without IF_PREFETCH_PERF_EN, omit both ports and counter logic; all other behaviour identical.

Structure
REQ-031 SHALL take default widths and RESET_PC from the shared CPU defines package (instruction address/data bus widths, reset vector).
REQ-032 SHALL place queue storage, pointers and count in one sub-module ifq_fifo (push, pop, flush, full, empty, head data).

Verification
REQ-033 Reset release, id_ready_i=1, ROM word=addr -> cycle 2 onward id_pc_o = 0,4,8,... one per cycle, id_inst_o matches.
REQ-034 id_ready_i=0 from reset, DEPTH=4 -> count reaches 4, rom_ce_o low, fetch_pc=0x10; on ready=1 PCs 0,4,8,0xC then 0x10 without gap >1 cycle.
REQ-035 branch_i=1, target 0x100, queue full, id_ready_i=1 -> t+1 rom_addr_o=0x100, id_valid_o=0; t+2 id_pc_o=0x100.
REQ-036 Full queue, pop each cycle -> push resumes cycle after count<4; order preserved across pointer wrap (>=3 wraps).
REQ-037 rst pulse mid-stream -> outputs zero immediately (asynchronous); first id_pc_o after release = RESET_PC at cycle 2.
REQ-038 IF_PREFETCH_PERF_EN, 10 stalled valid cycles, 20 fetches -> stall_cnt_o=10, fetch_cnt_o=20.
